boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream boot loader that sits directly upstream of the slave memory wrapper's boot write port. It parses a framed program image arriving from a UART receiver and writes it word-by-word into instruction/data memory. It holds the core in reset until a complete frame with a valid checksum has been loaded. `core_hold` is ORed into the core reset path at SoC level, after `rst_sync`.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.
- `DEPTH_WORDS`, 1024: maximum word count accepted; range 1..65535.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between bytes inside a frame.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid. Always accepted; there is no backpressure.
- `rx_data`  in  8  received byte.
- `boot_wr_en`  out  1  one-cycle memory write strobe.
- `boot_wr_addr`  out  32  byte address of the write, word aligned.
- `boot_wr_data`  out  32  write data.
- `core_hold`  out  1  1 = keep the core in reset.
- `boot_busy`  out  1  frame in progress (states LEN_LO..CSUM).
- `boot_done`  out  1  image loaded and verified; sticky until reset.
- `boot_err`  out  1  last frame failed; cleared by the next sync byte.

## Operation
- Frame format: SYNC_BYTE, then N as 2 bytes little-endian, then 4N data bytes, then a 1-byte checksum.
  - Data bytes form words little-endian: the first byte goes to [7:0].
  - Checksum = 8-bit modular sum of the 4N data bytes only.
- States and transitions:
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE → LEN_LO, clearing the checksum, word index and byte index.
  - LEN_LO: capture N[7:0] → LEN_HI.
  - LEN_HI: capture N[15:8]. If N==0 or N>DEPTH_WORDS → ERROR; otherwise → DATA.
  - DATA:
    - Shift each byte into the word assembly register and add it to the checksum.
    - On the 4th byte of a word, issue the write and increment the word index.
    - After word N-1 → CSUM.
  - CSUM: byte equal to the checksum → DONE; otherwise → ERROR.
  - DONE: `core_hold`=0, `boot_done`=1. All further bytes are ignored until reset; this state is terminal.
  - ERROR: `boot_err`=1 and `core_hold`=1. Behaves as IDLE: SYNC_BYTE clears `boot_err` and goes to LEN_LO.
- Write address = BASE_ADDR + 4*word_index. Word index is 16 bits and never wraps, because N ≤ DEPTH_WORDS.
- Words are written before the checksum is verified. On failure the memory contents are undefined, but the core stays held.
- Timeout: a counter clears on every accepted byte and counts cycles while in LEN_LO..CSUM. When it reaches TIMEOUT_CYCLES with no `rx_valid` that cycle, the FSM goes to ERROR.
- `rx_valid` is ignored on the cycle `reset` is high.

## Timing
- Reset values:
  - state = IDLE.
  - `boot_wr_en`=0, `boot_wr_addr`=BASE_ADDR, `boot_wr_data`=0.
  - `core_hold`=1, `boot_busy`=0, `boot_done`=0, `boot_err`=0.
  - All counters = 0.
- Reset asserted mid-frame aborts immediately to the reset values. No partial write is issued.
- All outputs are registered.
- `boot_wr_en` rises the cycle after the clock edge that samples the 4th byte of a word, and stays high exactly 1 cycle. Address and data are stable during that cycle.
- A state transition takes effect the cycle after the byte is sampled.
- `core_hold` falls, and `boot_done` rises, the cycle after a correct checksum byte is sampled.
- Back-to-back `rx_valid` on every cycle must be supported with no lost bytes. Consecutive writes can therefore be 4 cycles apart at minimum.
- A timeout on the same cycle as `rx_valid`: the byte wins and no error is raised.

## Test plan
- Reset: assert `reset` asynchronously between clock edges. Required: all outputs take their reset values immediately, and `core_hold`=1.
- Good frame: A5 02 00 11 22 33 44 55 66 77 88 64. Required:
  - Write addr 0x0 with data 0x44332211.
  - Write addr 0x4 with data 0x88776655.
  - Then `boot_done`=1 and `core_hold`=0.
  - Later bytes cause no writes.
- Bad checksum: the same frame ending in 65. Required: both writes occur, then `boot_err`=1, `core_hold`=1, `boot_done`=0. Then resend the good frame: `boot_err` clears on A5, and the load completes.
- Length limits:
  - A5 00 00 → ERROR after LEN_HI, with no writes.
  - N=DEPTH_WORDS+1 → ERROR.
  - N=DEPTH_WORDS loads fully; the last write is at address BASE_ADDR+4*(DEPTH_WORDS-1).
- Timeout: stall TIMEOUT_CYCLES after the 5th data byte. Required: `boot_err`=1 and `boot_busy`=0. Also send one byte exactly on the boundary cycle: required no error.
- Noise and reset: send bytes 00 FF 5A in IDLE. Required: ignored. Then assert `reset` in the middle of DATA. Required: no `boot_wr_en` pulse, and the FSM returns to IDLE.

Source files
------------

// File: rtl/boot_loader.sv
// Framed byte-stream boot loader: SYNC, 16-bit word count, little-endian data words, 8-bit sum.
// Streams each assembled word to the boot write port and keeps the core held until a frame verifies.
module boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        boot_wr_en,
    output logic [31:0] boot_wr_addr,
    output logic [31:0] boot_wr_data,
    output logic        core_hold,
    output logic        boot_busy,
    output logic        boot_done,
    output logic        boot_err
);

    localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]   DEPTH_LIM = 17'(DEPTH_WORDS);
    localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_next;
    logic [15:0]   frame_len;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    csum;
    logic [23:0]   word_buf;
    logic [TW-1:0] tmo_cnt;
    logic          in_frame;
    logic          tmo_hit;
    logic [15:0]   len_cand;

    assign in_frame = state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TMO_LIM);
    assign len_cand = {rx_data, frame_len[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ERROR: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    if (len_cand == 16'd0 || {1'b0, len_cand} > DEPTH_LIM) state_next = S_ERROR;
                    else                                                   state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid && byte_idx == 2'd3 && word_idx == frame_len - 16'd1) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (rx_valid) state_next = (rx_data == csum) ? S_DONE : S_ERROR;
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (tmo_hit) state_next = S_ERROR;
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_wr_en   <= 1'b0;
            boot_wr_addr <= BASE_ADDR;
            boot_wr_data <= 32'd0;
            core_hold    <= 1'b1;
            boot_busy    <= 1'b0;
            boot_done    <= 1'b0;
            boot_err     <= 1'b0;
            frame_len    <= 16'd0;
            word_idx     <= 16'd0;
            byte_idx     <= 2'd0;
            csum         <= 8'd0;
            word_buf     <= 24'd0;
            tmo_cnt      <= '0;
        end else begin
            boot_wr_en <= 1'b0;
            core_hold  <= (state_next != S_DONE);
            boot_done  <= (state_next == S_DONE);
            boot_err   <= (state_next == S_ERROR);
            boot_busy  <= state_next inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};

            if (!in_frame || rx_valid || tmo_hit) tmo_cnt <= '0;
            else                                  tmo_cnt <= tmo_cnt + TW'(1);

            if (rx_valid) begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (rx_data == SYNC_BYTE) begin
                            csum     <= 8'd0;
                            word_idx <= 16'd0;
                            byte_idx <= 2'd0;
                        end
                    end
                    S_LEN_LO: frame_len[7:0]  <= rx_data;
                    S_LEN_HI: frame_len[15:8] <= rx_data;
                    S_DATA: begin
                        csum     <= csum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Bytes enter at the top so the first byte ends up in [7:0].
                        if (byte_idx == 2'd3) begin
                            boot_wr_en   <= 1'b1;
                            boot_wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            boot_wr_data <= {rx_data, word_buf};
                            word_idx     <= word_idx + 16'd1;
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus random frames checked against
// a frame-level parser model (expected writes, their timing and the final load status).
module tb_boot_loader;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 8;
    localparam int          TMO   = 40;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        boot_wr_en;
    logic [31:0] boot_wr_addr;
    logic [31:0] boot_wr_data;
    logic        core_hold;
    logic        boot_busy;
    logic        boot_done;
    logic        boot_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_status;

    logic [7:0]  frame_q[$];
    int          gap_q[$];
    int          stamp_q[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_stamp[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_stamp[$];

    boot_loader #(
        .BASE_ADDR(BASE),
        .DEPTH_WORDS(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .boot_wr_en(boot_wr_en),
        .boot_wr_addr(boot_wr_addr),
        .boot_wr_data(boot_wr_data),
        .core_hold(core_hold),
        .boot_busy(boot_busy),
        .boot_done(boot_done),
        .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write strobe seen is logged with the index of the clock edge that produced it.
    always @(negedge clk) begin
        if (boot_wr_en === 1'b1) begin
            got_addr.push_back(boot_wr_addr);
            got_data.push_back(boot_wr_data);
            got_stamp.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        stamp_q.push_back(cyc + 1);
    endtask

    task automatic endStimulus();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic newFrame();
        frame_q.delete();
        gap_q.delete();
        stamp_q.delete();
        got_addr.delete();
        got_data.delete();
        got_stamp.delete();
    endtask

    task automatic pushByte(input logic [7:0] b, input int gap);
        frame_q.push_back(b);
        gap_q.push_back(gap);
    endtask

    task automatic pushGoodFrame(input logic [7:0] last);
        logic [7:0] body [12];
        body = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        body[11] = last;
        for (int i = 0; i < 12; i++) pushByte(body[i], 0);
    endtask

    task automatic buildRandomFrame(input int n, input bit corrupt, input int max_gap);
        int         sum;
        logic [7:0] b;
        sum = 0;
        pushByte(SYNC, 0);
        pushByte(8'(n), $urandom_range(0, max_gap));
        pushByte(8'(n >> 8), $urandom_range(0, max_gap));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            sum += int'(b);
            pushByte(b, $urandom_range(0, max_gap));
        end
        b = 8'(sum) + (corrupt ? 8'($urandom_range(1, 255)) : 8'd0);
        pushByte(b, $urandom_range(0, max_gap));
    endtask

    task automatic sendFrame(input int from_idx);
        for (int i = from_idx; i < frame_q.size(); i++) applyStimulus(frame_q[i], gap_q[i]);
        endStimulus();
    endtask

    // Parses the sent frame: count, words, modular sum; status 1 = loaded, 2 = rejected.
    task automatic modelFrame();
        int          n;
        int          sum;
        logic [31:0] word;
        exp_addr.delete();
        exp_data.delete();
        exp_stamp.delete();
        n = int'(frame_q[1]) + 256 * int'(frame_q[2]);
        if (n == 0 || n > DEPTH) begin
            exp_status = 2;
            return;
        end
        sum = 0;
        for (int w = 0; w < n; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
                word = word | (32'(frame_q[3 + 4 * w + b]) << (8 * b));
                sum += int'(frame_q[3 + 4 * w + b]);
            end
            exp_addr.push_back(BASE + 32'(4 * w));
            exp_data.push_back(word);
            exp_stamp.push_back(stamp_q[3 + 4 * w + 3]);
        end
        exp_status = (int'(frame_q[3 + 4 * n]) == sum % 256) ? 1 : 2;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, " wr_count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checkOutput($sformatf("%s wr%0d addr", tag, i), got_addr[i], exp_addr[i]);
            checkOutput($sformatf("%s wr%0d data", tag, i), got_data[i], exp_data[i]);
            checkOutput($sformatf("%s wr%0d cycle", tag, i), got_stamp[i], exp_stamp[i]);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, " done"}, boot_done, exp_status == 1);
        checkOutput({tag, " err"}, boot_err, exp_status == 2);
        checkOutput({tag, " hold"}, core_hold, exp_status != 1);
        checkOutput({tag, " busy"}, boot_busy, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst wr_en", boot_wr_en, 1'b0);
        checkOutput("rst wr_addr", boot_wr_addr, BASE);
        checkOutput("rst wr_data", boot_wr_data, 32'd0);
        checkOutput("rst hold", core_hold, 1'b1);
        checkOutput("rst busy", boot_busy, 1'b0);
        checkOutput("rst done", boot_done, 1'b0);
        checkOutput("rst err", boot_err, 1'b0);
        reset = 1'b0;

        $display("[TB] noise bytes in IDLE");
        newFrame();
        applyStimulus(8'h00, 0);
        applyStimulus(8'hFF, 0);
        applyStimulus(8'h5A, 0);
        endStimulus();
        repeat (2) @(negedge clk);
        checkOutput("noise busy", boot_busy, 1'b0);
        checkOutput("noise err", boot_err, 1'b0);
        checkOutput("noise hold", core_hold, 1'b1);
        checkOutput("noise wr_count", got_addr.size(), 0);

        $display("[TB] asynchronous reset in the middle of DATA");
        newFrame();
        pushGoodFrame(8'h64);
        for (int i = 0; i < 10; i++) applyStimulus(frame_q[i], 0);
        applyStimulus(frame_q[10], 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst wr_count before", got_addr.size(), 1);
        if (got_data.size() > 0) checkOutput("midrst wr0 data", got_data[0], 32'h4433_2211);
        checkOutput("midrst wr_en", boot_wr_en, 1'b0);
        checkOutput("midrst wr_addr", boot_wr_addr, BASE);
        checkOutput("midrst wr_data", boot_wr_data, 32'd0);
        checkOutput("midrst busy", boot_busy, 1'b0);
        checkOutput("midrst hold", core_hold, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst wr_count after", got_addr.size(), 1);
        checkOutput("midrst busy after", boot_busy, 1'b0);

        $display("[TB] good frame");
        newFrame();
        pushGoodFrame(8'h64);
        sendFrame(0);
        modelFrame();
        checkWrites("good");
        checkStatus("good");
        if (got_addr.size() == 2) begin
            checkOutput("good wr0 const", {got_addr[0], got_data[0]}, {BASE, 32'h4433_2211});
            checkOutput("good wr1 const", {got_addr[1], got_data[1]}, {BASE + 32'd4, 32'h8877_6655});
        end

        newFrame();
        pushGoodFrame(8'h64);
        sendFrame(0);
        repeat (2) @(negedge clk);
        checkOutput("after done wr_count", got_addr.size(), 0);
        checkOutput("after done done", boot_done, 1'b1);
        checkOutput("after done hold", core_hold, 1'b0);

        $display("[TB] bad checksum, then resend");
        doReset();
        newFrame();
        pushGoodFrame(8'h65);
        sendFrame(0);
        modelFrame();
        checkWrites("badcs");
        checkStatus("badcs");
        newFrame();
        pushGoodFrame(8'h64);
        applyStimulus(frame_q[0], 0);
        endStimulus();
        checkOutput("resync err", boot_err, 1'b0);
        checkOutput("resync busy", boot_busy, 1'b1);
        sendFrame(1);
        modelFrame();
        checkWrites("resend");
        checkStatus("resend");

        $display("[TB] length limits");
        doReset();
        newFrame();
        pushByte(SYNC, 0);
        pushByte(8'h00, 0);
        pushByte(8'h00, 0);
        sendFrame(0);
        modelFrame();
        checkWrites("len0");
        checkStatus("len0");

        newFrame();
        pushByte(SYNC, 0);
        pushByte(8'(DEPTH + 1), 0);
        pushByte(8'((DEPTH + 1) >> 8), 0);
        sendFrame(0);
        modelFrame();
        checkWrites("lenmax+1");
        checkStatus("lenmax+1");

        newFrame();
        buildRandomFrame(DEPTH, 1'b0, 0);
        sendFrame(0);
        modelFrame();
        checkWrites("lenmax");
        checkStatus("lenmax");
        if (got_addr.size() > 0) checkOutput("lenmax last addr", got_addr[$], BASE + 32'(4 * (DEPTH - 1)));

        $display("[TB] timeout after the 5th data byte");
        doReset();
        newFrame();
        pushGoodFrame(8'h64);
        for (int i = 0; i < 8; i++) applyStimulus(frame_q[i], 0);
        repeat (TMO + 1) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        checkOutput("stall edge busy", boot_busy, 1'b1);
        checkOutput("stall edge err", boot_err, 1'b0);
        @(negedge clk);
        checkOutput("stall err", boot_err, 1'b1);
        checkOutput("stall busy", boot_busy, 1'b0);
        checkOutput("stall hold", core_hold, 1'b1);
        checkOutput("stall wr_count", got_addr.size(), 1);

        $display("[TB] byte on the timeout boundary cycle");
        doReset();
        newFrame();
        pushGoodFrame(8'h64);
        gap_q[8] = TMO;
        sendFrame(0);
        modelFrame();
        checkWrites("boundary");
        checkStatus("boundary");

        $display("[TB] random frames");
        for (int t = 0; t < 8; t++) begin
            doReset();
            newFrame();
            buildRandomFrame($urandom_range(1, DEPTH), ($urandom_range(0, 3) == 0), 3);
            sendFrame(0);
            modelFrame();
            checkWrites($sformatf("rnd%0d", t));
            checkStatus($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
